// File: rtl/bcd_count_ctrl.sv
// Run/pause/load controller for a multi-digit BCD up/down counter with a built-in tick prescaler.
// Optional feature macro: BCD_COUNT_CTRL_AUTOSTOP_EN (saturate and pause at the terminal value).
module bcd_count_ctrl #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_FREQ = 1_000,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tick,
  output logic                  running,
  output logic                  wrap
);

  localparam int DIV = (CLK_FREQ / TICK_FREQ);
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int W   = 4 * DIGITS;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("bcd_count_ctrl: CLK_FREQ / TICK_FREQ must be at least 2");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_digits_check
    $error("bcd_count_ctrl: DIGITS must be 1 to 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   pre, pre_next;
  logic [W-1:0]    bcd_next, step_val, clamp_val;
  logic            tick_next, wrap_next, step_carry, advance;

  // Ripple carry/borrow through the digit chain; step_carry survives only when every digit rolled over.
  always_comb begin
    step_val   = bcd;
    step_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (step_carry) begin
        if (up_down) begin
          if (bcd[4*i +: 4] == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
            step_carry         = 1'b0;
          end
        end else begin
          if (bcd[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
            step_carry         = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    clamp_val = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) clamp_val[4*i +: 4] = 4'd9;
    end
  end

  // NOTE: every signal gets a default before the if-chain so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    pre_next   = pre;
    bcd_next   = bcd;
    tick_next  = 1'b0;
    wrap_next  = 1'b0;
    advance    = 1'b0;

    if (load) begin
      bcd_next = clamp_val;
      pre_next = '0;
    end else if (stop) begin
      if (state == RUN) begin
        state_next = PAUSED;
      end else begin
        state_next = IDLE;
        bcd_next   = '0;
      end
    end else if (start && state == IDLE) begin
      state_next = RUN;
      pre_next   = '0;
    end else if (state == RUN || (start && state == PAUSED)) begin
      // Resuming from PAUSED counts on the resume edge, continuing from the frozen value.
      state_next = RUN;
      advance    = 1'b1;
    end

    if (advance) begin
      if (pre == PRE_LAST) begin
        pre_next  = '0;
        tick_next = 1'b1;
        wrap_next = step_carry;
`ifdef BCD_COUNT_CTRL_AUTOSTOP_EN
        if (step_carry) state_next = PAUSED;
        else            bcd_next   = step_val;
`else
        bcd_next = step_val;
`endif
      end else begin
        pre_next = pre + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pre     <= '0;
      bcd     <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      pre     <= pre_next;
      bcd     <= bcd_next;
      tick    <= tick_next;
      wrap    <= wrap_next;
      running <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Self-checking bench for bcd_count_ctrl: directed scenarios plus random commands against an integer-valued model.
module tb_bcd_count_ctrl;

  localparam int CLK_FREQ  = 20;
  localparam int TICK_FREQ = 2;
  localparam int DIGITS    = 2;
  localparam int DIV       = CLK_FREQ / TICK_FREQ;
  localparam int MOD       = 100;
  localparam int W         = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0, stop = 1'b0, up_down = 1'b1, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] bcd;
  logic         tick, running, wrap;

  bcd_count_ctrl #(.CLK_FREQ(CLK_FREQ), .TICK_FREQ(TICK_FREQ), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .up_down(up_down),
    .load(load), .load_val(load_val), .bcd(bcd), .tick(tick), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: count held as a plain integer 0..MOD-1, prescaler as a count of elapsed run cycles.
  typedef enum {M_IDLE, M_RUN, M_PAUSED} mode_t;
  mode_t m_mode;
  int    m_val, m_pre;
  bit    m_tick, m_wrap, m_run;

  function automatic logic [W-1:0] enc(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int dec_clamp(input logic [W-1:0] b);
    int v, p, d;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_val = 0; m_pre = 0;
    m_tick = 0; m_wrap = 0; m_run = 0;
  endtask

  task automatic model_step();
    bit adv;
    int nxt;
    adv = 0;
    m_tick = 0;
    m_wrap = 0;
    if (load) begin
      m_val = dec_clamp(load_val);
      m_pre = 0;
    end else if (stop) begin
      if (m_mode == M_RUN) m_mode = M_PAUSED;
      else begin m_mode = M_IDLE; m_val = 0; end
    end else if (start && m_mode == M_IDLE) begin
      m_mode = M_RUN;
      m_pre  = 0;
    end else if (m_mode == M_RUN || start) begin
      m_mode = M_RUN;
      adv    = 1;
    end
    if (adv) begin
      m_pre++;
      if (m_pre == DIV) begin
        m_pre  = 0;
        m_tick = 1;
        nxt = up_down ? m_val + 1 : m_val - 1;
        if (nxt < 0 || nxt >= MOD) begin
          m_wrap = 1;
`ifdef BCD_COUNT_CTRL_AUTOSTOP_EN
          m_mode = M_PAUSED;
`else
          m_val = (nxt + MOD) % MOD;
`endif
        end else begin
          m_val = nxt;
        end
      end
    end
    m_run = (m_mode == M_RUN);
  endtask

  task automatic compare_all();
    check("bcd", {24'd0, bcd}, {24'd0, enc(m_val)});
    check("tick", {31'd0, tick}, {31'd0, m_tick});
    check("wrap", {31'd0, wrap}, {31'd0, m_wrap});
    check("running", {31'd0, running}, {31'd0, m_run});
  endtask

  // Inputs are set at the falling edge; the model follows the rising edge; outputs are compared at the next falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  int ticks, n;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_bcd", {24'd0, bcd}, 32'h0);
    check("rst_flags", {29'd0, tick, running, wrap}, 32'h0);
    rst = 1'b1;
    cycle();

    // Reset and first ticks
    start = 1; up_down = 1; cycle(); start = 0;
    check("running_rise", {31'd0, running}, 32'd1);
    run(9);
    check("no_early_tick", {31'd0, tick}, 32'd0);
    cycle();
    check("first_tick", {31'd0, tick}, 32'd1);
    check("first_bcd", {24'd0, bcd}, 32'h01);
    run(10);
    check("second_bcd", {24'd0, bcd}, 32'h02);

    // Up wrap
    load = 1; load_val = 8'h99; cycle(); load = 0;
    run(9); cycle();
`ifdef BCD_COUNT_CTRL_AUTOSTOP_EN
    check("up_wrap_bcd", {24'd0, bcd}, 32'h99);
    check("up_wrap_running", {31'd0, running}, 32'd0);
`else
    check("up_wrap_bcd", {24'd0, bcd}, 32'h00);
`endif
    check("up_wrap_pulse", {31'd0, wrap}, 32'd1);
    cycle();
    check("wrap_one_cycle", {31'd0, wrap}, 32'd0);
    stop = 1; run(2); stop = 0;
    check("clear_idle", {24'd0, bcd}, 32'h00);

    // Down borrow
    load = 1; load_val = 8'h10; up_down = 0; cycle(); load = 0;
    start = 1; cycle(); start = 0;
    run(9); cycle();
    check("down_09", {24'd0, bcd}, 32'h09);
    run(10);
    check("down_08", {24'd0, bcd}, 32'h08);
    load = 1; load_val = 8'h00; cycle(); load = 0;
    run(9); cycle();
`ifdef BCD_COUNT_CTRL_AUTOSTOP_EN
    check("down_wrap_bcd", {24'd0, bcd}, 32'h00);
`else
    check("down_wrap_bcd", {24'd0, bcd}, 32'h99);
`endif
    check("down_wrap_pulse", {31'd0, wrap}, 32'd1);
    stop = 1; run(2); stop = 0;

    // Pause and resume with the prescaler frozen at 4
    up_down = 1;
    start = 1; cycle(); start = 0;
    run(4);
    stop = 1; cycle(); stop = 0;
    ticks = 0;
    repeat (30) begin
      cycle();
      if (tick) ticks++;
    end
    check("pause_no_tick", ticks, 0);
    start = 1; cycle(); start = 0;
    n = 0;
    while (n < 20) begin
      cycle();
      n++;
      if (tick) break;
    end
    check("resume_latency", n, 5);
    stop = 1; cycle();
    check("stop_pauses", {31'd0, running}, 32'd0);
    cycle(); stop = 0;
    check("stop_clears", {24'd0, bcd}, 32'h00);

    // Stop on the step edge wins
    start = 1; cycle(); start = 0;
    run(9);
    stop = 1; cycle(); stop = 0;
    check("stop_wins_tick", {31'd0, tick}, 32'd0);
    stop = 1; cycle(); stop = 0;

    // Priority and clamping, colliding with a step
    start = 1; cycle(); start = 0;
    run(9);
    load = 1; stop = 1; load_val = 8'hA7; cycle(); load = 0; stop = 0;
    check("prio_bcd", {24'd0, bcd}, 32'h97);
    check("prio_running", {31'd0, running}, 32'd1);
    check("prio_tick", {31'd0, tick}, 32'd0);

    // Asynchronous reset mid-count
    load = 1; load_val = 8'h42; cycle(); load = 0;
    run(3);
    check("pre_reset_bcd", {24'd0, bcd}, 32'h42);
    #2 rst = 1'b0;
    #1;
    check("async_bcd", {24'd0, bcd}, 32'h0);
    check("async_flags", {29'd0, tick, running, wrap}, 32'h0);
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b1;

    // Random commands
    repeat (2000) begin
      start    = ($urandom % 8) == 0;
      stop     = ($urandom % 16) == 0;
      load     = ($urandom % 32) == 0;
      load_val = W'($urandom);
      if (($urandom % 64) == 0) up_down = ~up_down;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_count_ctrl.md
# bcd_count_ctrl

Run/pause/load controller for the multi-digit BCD up/down counter on the practice boards. It generates a single-cycle count-enable tick from the 50 MHz system clock. It does this with an internal prescaler, so the design has no divided clock and no second clock domain. It then sequences the BCD digit chain through idle, run and pause states under push-button control. Its `bcd` output drives the seven-segment decoders directly.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `TICK_FREQ`, 1_000: count rate in Hz.
  - Prescaler divide is DIV = CLK_FREQ / TICK_FREQ, integer division, fully parenthesised.
  - DIV must be at least 2.
- `DIGITS`, 4: number of BCD digits, 1 to 8.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: level, synchronous; enters RUN.
- `stop`  in  1: level, synchronous; pause, or clear when already paused.
- `up_down`  in  1: 1 = count up, 0 = count down; sampled on each tick.
- `load`  in  1: synchronous parallel load of `load_val`.
- `load_val`  in  4*DIGITS: BCD value to load; digit i is bits [4i+3:4i].
- `bcd`  out  4*DIGITS: current count, registered.
- `tick`  out  1: one-cycle pulse on every count step.
- `running`  out  1: high in RUN.
- `wrap`  out  1: one-cycle pulse when the count passes its terminal value.

## Operation
- **FSM states:** IDLE, RUN, PAUSED. Reset state is IDLE.
- **Command priority** (evaluated each cycle): `load` > `stop` > `start`.
- **`load`, any state:**
  - `bcd` <= `load_val`, with any digit above 9 clamped to 9.
  - State is unchanged.
  - Prescaler is cleared to 0.
  - No `tick` and no `wrap` that cycle.
- **IDLE:**
  - `start` -> RUN, with the prescaler cleared to 0.
  - `stop` -> stays IDLE with `bcd` cleared to 0.
- **RUN:**
  - Prescaler counts 0 to DIV-1 and wraps.
  - At prescaler == DIV-1, the next edge steps the count and asserts `tick`.
  - `stop` -> PAUSED; the prescaler freezes at its current value.
  - `start` has no effect.
- **PAUSED:**
  - `start` -> RUN; the prescaler resumes from its frozen value.
  - `stop` -> IDLE with `bcd` cleared to 0. Holding `stop` from RUN therefore pauses, then clears on the next cycle.
- **Count step, up:** digit 0 increments. Any digit at 9 becomes 0 and carries to the next digit within the same cycle.
- **Count step, down:** digit 0 decrements. Any digit at 0 becomes 9 and borrows from the next digit within the same cycle.
- **Terminal values:** all-9s when counting up, all-0s when counting down.
  - Stepping past a terminal value wraps the count: up goes from all-9s to all-0s, down goes from all-0s to all-9s.
  - `wrap` asserts on that same edge.
- A change of `up_down` between ticks is legal. The value at the tick edge decides the step direction.

## Timing
- **Reset values:** `bcd` = 0, `tick` = 0, `running` = 0, `wrap` = 0; prescaler = 0; state IDLE.
- Reset asserts asynchronously. Deassertion is synchronised externally.
- **Reset in mid-count:** everything returns immediately to reset values, with no partial step.
- **Step latency:**
  - First tick comes DIV cycles after the `start` edge taken from IDLE.
  - Thereafter there is exactly one tick every DIV cycles while in RUN.
- `tick`, `wrap` and the `bcd` update are all registered and change on the same edge.
- `running` is registered and rises on the edge that enters RUN.
- **Same-cycle command collisions:**
  - If `stop` coincides with the prescaler reaching DIV-1, `stop` wins: no step, no tick.
  - If `load` coincides with a step, the step is discarded.

## Configuration
- Macro: `BCD_COUNT_CTRL_AUTOSTOP_EN`.
- **Defined:**
  - A step at a terminal value saturates: `bcd` stays all-9s (up) or all-0s (down).
  - `wrap` pulses once and `tick` is still asserted.
  - The FSM goes to PAUSED on the same edge.
- **Undefined:** the count wraps freely and the FSM stays in RUN.

## Test plan
All scenarios use CLK_FREQ=20, TICK_FREQ=2 (DIV=10) and DIGITS=2 unless stated otherwise.
- **Reset and first ticks:** hold `rst`=0, release it, pulse `start`, `up_down`=1.
  - Required: `running`=1 one edge later; first `tick` 10 cycles after the start edge; `bcd`=0x01, then 0x02 ten cycles later.
- **Up wrap:** load 0x99, `start`, `up_down`=1.
  - Required: at the first tick `bcd`=0x00 and `wrap`=1 for one cycle.
  - With `BCD_COUNT_CTRL_AUTOSTOP_EN`: `bcd` stays 0x99, `wrap`=1, `running`=0.
- **Down borrow:** load 0x10, `up_down`=0, `start`.
  - Required: 0x09, then 0x08 on successive ticks; from 0x00 the next step gives 0x99 with `wrap`=1.
- **Pause/resume:** `stop` when the prescaler is at 4, hold PAUSED for 30 cycles, then `start`.
  - Required: no tick while paused; next tick 5 cycles after resume.
  - A second `stop` while PAUSED clears `bcd` to 0x00 and enters IDLE.
- **Priority and clamping:** assert `load` with `load_val`=0xA7 together with `stop` in RUN.
  - Required: `bcd`=0x97, state stays RUN, no tick.
- **Asynchronous reset mid-count:** drop `rst` at `bcd`=0x42 between clock edges.
  - Required: all outputs are 0 immediately, before the next edge.
